// File: rtl/data_sram_responder.sv
// Data-memory responder: byte-lane writes into a word array, reads sampled at acceptance,
// completion signalled by a one-cycle data_ok pulse LATENCY cycles after acceptance.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [31:0]      mem_word;
  logic             accept;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_WIDTH], data_sram_addr[1:0]};

  assign idx      = data_sram_addr[ADDR_WIDTH-1:2];
  assign mem_word = mem[idx];

  // addr_ok is forced low while reset is held, even though the state already reads IDLE.
  assign data_sram_addr_ok = ~reset & (state_q != WAIT);
  assign data_sram_data_ok = (state_q == RESP);
  assign data_sram_rdata   = rdata_q;
  assign accept            = data_sram_req & data_sram_addr_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          rd_d  = ~data_sram_wr;
          buf_d = mem_word;
          if (LATENCY == 1) begin
            state_d = RESP;
            if (!data_sram_wr) rdata_d = mem_word;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          if (rd_q) rdata_d = buf_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      buf_q   <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
    end
  end

  // Array contents survive reset; a write commits at its acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder at LATENCY 1, 3 and 4.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req   [3];
  logic        wr    [3];
  logic [3:0]  wstrb [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        addr_ok [3];
  logic        data_ok [3];
  logic [31:0] rdata   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_WIDTH(16), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .data_sram_req(req[0]), .data_sram_wr(wr[0]), .data_sram_wstrb(wstrb[0]),
    .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
    .data_sram_addr_ok(addr_ok[0]), .data_sram_data_ok(data_ok[0]), .data_sram_rdata(rdata[0])
  );

  data_sram_responder #(.ADDR_WIDTH(16), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset),
    .data_sram_req(req[1]), .data_sram_wr(wr[1]), .data_sram_wstrb(wstrb[1]),
    .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
    .data_sram_addr_ok(addr_ok[1]), .data_sram_data_ok(data_ok[1]), .data_sram_rdata(rdata[1])
  );

  data_sram_responder #(.ADDR_WIDTH(16), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset),
    .data_sram_req(req[2]), .data_sram_wr(wr[2]), .data_sram_wstrb(wstrb[2]),
    .data_sram_addr(addr[2]), .data_sram_wdata(wdata[2]),
    .data_sram_addr_ok(addr_ok[2]), .data_sram_data_ok(data_ok[2]), .data_sram_rdata(rdata[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic r, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    req[k]   = r;
    wr[k]    = w;
    wstrb[k] = s;
    addr[k]  = a;
    wdata[k] = d;
  endtask

  // One full transaction; returns sitting at the negedge of the data_ok cycle.
  task automatic txn(input int k, input logic w, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] d, input int lat, input string tag);
    int n;
    next_cycle();
    drive(k, 1'b1, w, s, a, d);
    @(negedge clk);
    check({tag, " addr_ok"}, 32'(addr_ok[k]), 32'd1);
    next_cycle();
    drive(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    n = 1;
    @(negedge clk);
    while (!data_ok[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Reset asserted mid-clock for three cycles.
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("rst addr_ok[%0d]", k), 32'(addr_ok[k]), 32'd0);
        check($sformatf("rst data_ok[%0d]", k), 32'(data_ok[k]), 32'd0);
        check($sformatf("rst rdata[%0d]", k), rdata[k], 32'd0);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    next_cycle();
    for (int k = 0; k < 3; k++) check($sformatf("post-rst addr_ok[%0d]", k), 32'(addr_ok[k]), 32'd1);

    // LATENCY 1: write then read back-to-back.
    drive(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'h1234_5678);
    @(negedge clk);
    check("l1 wr addr_ok", 32'(addr_ok[0]), 32'd1);
    next_cycle();
    drive(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    @(negedge clk);
    check("l1 wr data_ok", 32'(data_ok[0]), 32'd1);
    check("l1 rd addr_ok", 32'(addr_ok[0]), 32'd1);
    next_cycle();
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("l1 rd data_ok", 32'(data_ok[0]), 32'd1);
    check("l1 rd rdata", rdata[0], 32'h1234_5678);
    next_cycle();
    @(negedge clk);
    check("l1 idle data_ok", 32'(data_ok[0]), 32'd0);
    check("l1 rdata hold", rdata[0], 32'h1234_5678);

    // Partial write into lanes 0 and 2.
    txn(0, 1'b1, 4'b0101, 32'h10, 32'hAABB_CCDD, 1, "l1 partial wr");
    check("l1 wr keeps rdata", rdata[0], 32'h1234_5678);
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, 1, "l1 partial rd");
    check("l1 partial rdata", rdata[0], 32'h12BB_56DD);

    // Aliasing, plus a zero-strobe write that must still complete.
    txn(0, 1'b1, 4'hF, 32'h0000_0010, 32'h5A5A_5A5A, 1, "l1 alias wr");
    txn(0, 1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 1, "l1 nostrb wr");
    txn(0, 1'b0, 4'h0, 32'h0001_0013, 32'h0, 1, "l1 alias rd");
    check("l1 alias rdata", rdata[0], 32'h5A5A_5A5A);

    // LATENCY 3 with req held high through the wait.
    txn(1, 1'b1, 4'hF, 32'h40, 32'h1122_3344, 3, "l3 wr");
    next_cycle();
    drive(1, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    @(negedge clk);
    check("l3 t addr_ok", 32'(addr_ok[1]), 32'd1);
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("l3 t+%0d addr_ok", c), 32'(addr_ok[1]), 32'd0);
      check($sformatf("l3 t+%0d data_ok", c), 32'(data_ok[1]), 32'd0);
    end
    next_cycle();
    @(negedge clk);
    check("l3 t+3 data_ok", 32'(data_ok[1]), 32'd1);
    check("l3 t+3 addr_ok", 32'(addr_ok[1]), 32'd1);
    check("l3 t+3 rdata", rdata[1], 32'h1122_3344);
    next_cycle();
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("l3 t+4 addr_ok", 32'(addr_ok[1]), 32'd0);
    check("l3 t+4 data_ok", 32'(data_ok[1]), 32'd0);
    next_cycle();
    @(negedge clk);
    check("l3 t+5 data_ok", 32'(data_ok[1]), 32'd0);
    next_cycle();
    @(negedge clk);
    check("l3 t+6 data_ok", 32'(data_ok[1]), 32'd1);
    check("l3 t+6 rdata", rdata[1], 32'h1122_3344);

    // LATENCY 4: reset pulse while a write is waiting.
    next_cycle();
    drive(2, 1'b1, 1'b1, 4'hF, 32'h20, 32'hCAFE_F00D);
    @(negedge clk);
    check("l4 wr addr_ok", 32'(addr_ok[2]), 32'd1);
    next_cycle();
    drive(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("l4 wait addr_ok", 32'(addr_ok[2]), 32'd0);
    reset = 1'b1;
    #1;
    check("l4 rst data_ok", 32'(data_ok[2]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (data_ok[2]) pulses++;
    end
    check("l4 aborted data_ok count", 32'(pulses), 32'd0);
    txn(2, 1'b0, 4'h0, 32'h20, 32'h0, 4, "l4 rd");
    check("l4 rd rdata", rdata[2], 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder (slave) end of the data-memory interface driven by the pipeline's memory stage.
- Accepts one read or write request per handshake and performs byte-lane writes into a word-organised internal memory array.
- Returns read data after a programmable fixed latency and signals completion with a one-cycle data_ok pulse.
- Serves as the data RAM in simulation and SoC-lite builds. It is also the reference responder for verifying the memory stage's request/response timing.

Parameters:
ADDR_WIDTH, 16, byte-address bits decoded; array depth = 2^(ADDR_WIDTH-2) 32-bit words
LATENCY, 1, cycles from acceptance edge to data_ok cycle; legal range 1..15

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
data_sram_req  input  1  request valid
data_sram_wr  input  1  1 = write, 0 = read
data_sram_wstrb  input  4  byte write enables, bit i -> wdata[8i+7:8i]
data_sram_addr  input  32  byte address
data_sram_wdata  input  32  write data
data_sram_addr_ok  output  1  request accepted this cycle when high together with req
data_sram_data_ok  output  1  one-cycle response pulse
data_sram_rdata  output  32  read data, valid while data_ok is high for a read

Behaviour:
- Reset is asynchronous and active-high.
  - While reset is high: state = IDLE, addr_ok = 0, data_ok = 0, rdata = 0, counter = 0.
  - Memory array contents are not reset.
- Acceptance: the request is accepted at the rising edge that ends a cycle with data_sram_req && data_sram_addr_ok both high. At most one transaction is outstanding.
- Addressing: word index = addr[ADDR_WIDTH-1:2]. Bits addr[1:0] and addr[31:ADDR_WIDTH] are ignored, so aliases map to the same word.
- Write: committed to the array at the acceptance edge. Only lanes with wstrb bit set are updated. wstrb = 0 is a no-op write but still produces data_ok. rdata is not modified by writes.
- Read: the array word is sampled at the acceptance edge. A read accepted one cycle after a write to the same word returns the new data.
- State machine has three states: IDLE, WAIT, RESP.
  - IDLE: addr_ok = 1, data_ok = 0. On accept, go to RESP if LATENCY = 1. Otherwise load the counter with LATENCY-1 and go to WAIT.
  - WAIT: addr_ok = 0, data_ok = 0. The counter decrements each cycle. When the counter equals 1, the next state is RESP. A req held high during WAIT is ignored and not accepted.
  - RESP: data_ok = 1 for exactly this cycle; rdata holds the read result. addr_ok = 1, so a new request can be accepted in the same cycle. On accept, apply the same transitions as from IDLE. Otherwise go to IDLE.
- Timing:
  - With LATENCY = L, data_ok is high in cycle t+L for a request accepted at the end of cycle t.
  - With LATENCY = 1, back-to-back requests complete one per cycle.
- rdata holds the value of the last read response until the next read response or reset.
- data_ok has no backpressure; the requester must consume it in the pulse cycle.
- Reset in WAIT or RESP aborts the transaction: no further data_ok pulse. A write already committed at its acceptance edge persists.
- Inputs other than req are don't-care when req is low or addr_ok is low.

Test Plan:
- Reset sequence:
  - Stimulus: assert reset for 3 cycles mid-clock, then release.
  - Required: addr_ok = 0, data_ok = 0, rdata = 0 during reset; addr_ok = 1 the first cycle after release.
- LATENCY = 1 back-to-back:
  - Stimulus: write 0x12345678, wstrb 0xF, addr 0x10; next cycle read addr 0x10.
  - Required: data_ok high in both following cycles; rdata = 0x12345678 in the read's data_ok cycle.
- Partial write:
  - Stimulus: word 0x10 holds 0x12345678; write wdata 0xAABBCCDD with wstrb 0b0101; then read 0x10.
  - Required: read returns 0x12BB56DD.
- LATENCY = 3:
  - Stimulus: read accepted at end of cycle t; req held high through t+3.
  - Required: addr_ok = 0 and data_ok = 0 in t+1 and t+2; data_ok = 1 and addr_ok = 1 in t+3; the second request is accepted only at the end of t+3.
- Reset during WAIT (LATENCY = 4):
  - Stimulus: write 0xCAFEF00D to 0x20, pulse reset during WAIT, then read 0x20.
  - Required: no data_ok for the aborted write; the read returns 0xCAFEF00D.
- Address aliasing (ADDR_WIDTH = 16):
  - Stimulus: write 0x5A5A5A5A to 0x00000010; read 0x00010013.
  - Required: rdata = 0x5A5A5A5A.
